// File: rtl/tx_buffer_pkg.sv
// Shared constants and types for the TX buffer controller register window.
package tx_buffer_pkg;

  // Register window geometry: 4 KiB, split into four 1 KiB regions by off[11:10].
  localparam int unsigned WIN_SIZE = 4096;

  // Region encodings (off[11:10]).
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS word bit positions.
  localparam int unsigned STAT_OVF_BIT   = 31;
  localparam int unsigned STAT_AFULL_BIT = 30;
  localparam int unsigned STAT_FULL_BIT  = 29;
  localparam int unsigned STAT_EMPTY_BIT = 28;
  localparam int unsigned STAT_CNT_LSB   = 0;
  localparam int unsigned STAT_CNT_W     = 16;

  // CTRL write bit positions.
  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;

  // STATUS read word layout.
  typedef struct packed {
    logic        ovf;
    logic        afull;
    logic        full;
    logic        empty;
    logic [11:0] rsvd;
    logic [15:0] count;
  } status_t;

endpackage

// File: rtl/tx_chan_fifo.sv
// Single-channel synchronous FWFT FIFO with flush, count and almost-full.
// The head word is read combinationally from storage and forced to zero while empty.
module tx_chan_fifo #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned AFULL_TH = 496,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          afull_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign afull_o = (32'(count_q) >= AFULL_TH);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

  // Next-state pointers and occupancy; flush overrides any traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port; contents need no reset since empty masks the head.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tx_buffer_ctrl_gen.sv
// Generic N-channel TX buffer controller: decodes bus writes into per-channel FWFT FIFOs,
// and exposes status/control through a 4 KiB register window.
module tx_buffer_ctrl_gen
  import tx_buffer_pkg::*;
#(
  parameter int unsigned N_CH      = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AFULL_TH  = 496,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk_125,
  input  logic                 rst_125,
  input  logic [N_CH-1:0]      mon_tx_en,
  input  logic [N_CH-1:0]      tx_fifo_rden,
  output logic [N_CH*DW-1:0]   tx_fifo_data,
  output logic [N_CH-1:0]      tx_fifo_empty,
  output logic [N_CH-1:0]      tx_fifo_afull,
  output logic [N_CH*CW-1:0]   tx_fifo_rd_num,
  input  logic [31:0]          peripheral_data_in,
  input  logic [31:0]          peripheral_addr_in,
  input  logic                 peripheral_read_en,
  input  logic                 peripheral_write_en,
  output logic [31:0]          peripheral_data_out,
  output logic                 peripheral_data_out_en,
  output logic                 ovf_irq
);

  // Address decode.
  logic [31:0]     off;
  logic            in_win;
  logic [1:0]      region;
  logic [7:0]      ch;
  logic            ch_mapped;
  logic [N_CH-1:0] ch_sel;

  assign off       = peripheral_addr_in - BASE_ADDR;
  assign in_win    = (peripheral_addr_in >= BASE_ADDR) && (off < WIN_SIZE);
  assign region    = off[11:10];
  assign ch        = off[9:2];
  assign ch_mapped = in_win && (32'(ch) < N_CH);

  // One-hot channel select for the addressed, mapped channel.
  always_comb begin
    ch_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_sel[i] = ch_mapped && (32'(ch) == i);
    end
  end

  // Per-channel strobes.
  logic [N_CH-1:0] data_wr, ctrl_wr, stat_rd;
  logic [N_CH-1:0] fifo_full, fifo_empty, fifo_afull;
  logic [N_CH-1:0] pop_ok, push, flush;
  logic [N_CH-1:0] ovf_set, ovf_clr;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [CW-1:0]   cnt [N_CH];

  assign data_wr = {N_CH{peripheral_write_en && (region == REG_DATA)}} & ch_sel;
  assign ctrl_wr = {N_CH{peripheral_write_en && (region == REG_CTRL)}} & ch_sel;
  assign stat_rd = {N_CH{peripheral_read_en && (region == REG_STATUS)}} & ch_sel;

  assign pop_ok  = tx_fifo_rden & ~fifo_empty;
  assign push    = data_wr & mon_tx_en & (~fifo_full | pop_ok);
  // A disabled channel is held flushed every cycle.
  assign flush   = ~mon_tx_en | (ctrl_wr & {N_CH{peripheral_data_in[CTRL_FLUSH_BIT]}});
  assign ovf_set = data_wr & (~mon_tx_en | (fifo_full & ~pop_ok));
  assign ovf_clr = stat_rd | (ctrl_wr & {N_CH{peripheral_data_in[CTRL_OVF_CLR_BIT]}});
  // Set wins over a same-cycle clear.
  assign ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tx_chan_fifo #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH)
    ) u_fifo (
      .clk_i   (clk_125),
      .rst_i   (rst_125),
      .flush_i (flush[g]),
      .push_i  (push[g]),
      .wdata_i (peripheral_data_in[DW-1:0]),
      .pop_i   (tx_fifo_rden[g]),
      .rdata_o (tx_fifo_data[g*DW +: DW]),
      .count_o (cnt[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g]),
      .afull_o (fifo_afull[g])
    );
    assign tx_fifo_rd_num[g*CW +: CW] = cnt[g];
  end

  assign tx_fifo_empty = fifo_empty;
  assign tx_fifo_afull = fifo_afull;

  // STATUS word for the addressed channel; returns the pre-clear overflow flag.
  status_t     stat;
  logic [31:0] rd_data_d;

  always_comb begin
    stat = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_sel[i]) begin
        stat.ovf   = ovf_q[i];
        stat.afull = fifo_afull[i];
        stat.full  = fifo_full[i];
        stat.empty = fifo_empty[i];
        stat.count = 16'(cnt[i]);
      end
    end
  end

  // Every read gets a response; only a mapped STATUS read returns non-zero data.
  always_comb begin
    rd_data_d = '0;
    if (peripheral_read_en && ch_mapped && (region == REG_STATUS)) rd_data_d = stat;
  end

  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        irq_q;

  // Overflow flags, interrupt and read-response registers.
  always_ff @(posedge clk_125) begin
    if (rst_125) begin
      ovf_q      <= '0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ovf_q      <= ovf_d;
      irq_q      <= |ovf_d;
      rd_valid_q <= peripheral_read_en;
      rd_data_q  <= rd_data_d;
    end
  end

  assign peripheral_data_out    = rd_data_q;
  assign peripheral_data_out_en = rd_valid_q;
  assign ovf_irq                = irq_q;

  // Upper data bits are meaningless when DW < 32.
  logic unused_data;
  assign unused_data = ^peripheral_data_in;

endmodule
